pc_ras_unit: RTL and testbench
==============================

Name: pc_ras_unit

Overview:
Parametrised fetch-stage program counter for the pipelined core. It is the successor to the plain PC register.
- Selects the next fetch address from four sources, in priority order: EX-stage redirect, return-address-stack (RAS) return prediction, ID-stage jump target, sequential increment.
- Holds a circular RAS of RAS_DEPTH entries so that returns are predicted without waiting for EX.
- Sits between the hazard/branch logic and the instruction-memory address port.

Parameters:
WIDTH, 16, address width in bits
RESET_VECTOR, 0, PC value while and after reset
INC, 1, sequential increment per fetch
RAS_DEPTH, 4, RAS entries (power of two, >=2)

Ports:
Clk  input  1  clock, rising-edge
Reset_N  input  1  asynchronous active-low reset
pcWrite  input  1  1 = advance PC; 0 = stall (hold)
redirectValid  input  1  EX mispredict/resolve redirect
redirectAddr  input  WIDTH  redirect target
jumpValid  input  1  ID decoded direct jump/call taken
jumpAddr  input  WIDTH  ID jump target
callValid  input  1  ID instruction is a call; push pushAddr
pushAddr  input  WIDTH  return address to push
retValid  input  1  ID instruction is a return; pop
outputAddr  output  WIDTH  current PC (registered)
nextAddr  output  WIDTH  combinational next-PC value
rasHit  output  1  combinational; retValid accepted with RAS non-empty
rasEmpty  output  1  registered, count==0
rasFull  output  1  registered, count==RAS_DEPTH

Behaviour:
Reset:
- Reset_N low asynchronously forces outputAddr=RESET_VECTOR, RAS count=0 and top pointer=0.
- During reset: rasEmpty=1, rasFull=0.
- RAS entry contents after reset are don't-care.
- The first rising edge after Reset_N deasserts performs a normal update. There is no extra hold cycle.

Next-PC selection (combinational, priority high to low):
1. redirectValid: nextAddr=redirectAddr.
2. retValid && !rasEmpty: nextAddr=RAS top.
3. jumpValid: nextAddr=jumpAddr.
4. Otherwise: nextAddr=outputAddr+INC, truncated to WIDTH (wraps 0xFFFF+1 -> 0x0000 at WIDTH=16).
- retValid with the RAS empty falls through to source 3 or 4; rasHit=0 in that case.

PC register update:
- outputAddr<=nextAddr on each edge where (pcWrite || redirectValid).
- redirectValid overrides a stall.
- pcWrite=0 with no redirect: outputAddr holds.

RAS operations happen only on edges where pcWrite=1 and redirectValid=0. A redirect squashes the ID-stage call or return, so the RAS is not modified. The RAS is not repaired on mispredict.
- Push only (callValid): write pushAddr at top+1 (mod RAS_DEPTH), then top++.
  - count++, saturating at RAS_DEPTH.
  - Push when full overwrites the oldest entry (circular); count stays RAS_DEPTH.
- Pop only (retValid, non-empty): top-- (mod RAS_DEPTH), count--.
- Pop on empty: no state change.
- Push and pop in the same cycle: the top entry is replaced by pushAddr.
  - Pointer and count are unchanged.
  - The predicted target is the old top value.
  - If the RAS is empty: treat as push only.
- rasEmpty and rasFull update with count on the same edge.

Latency and consistency:
- nextAddr is combinational, with zero latency from inputs.
- outputAddr reflects a selection one cycle later.
- Asserting jumpValid and retValid together is legal; the return wins when the RAS is non-empty.
- A call combined with a jump (callValid and jumpValid both high) is the normal call case.
- Reset asserted mid-operation clears pointer, count and PC immediately, independent of Clk.

Test Plan:
- Reset, then 3 edges with pcWrite=1 and no other inputs -> outputAddr 0,1,2,3; rasEmpty=1.
- pcWrite=0 for 2 edges at PC=5, then redirectValid=1 with redirectAddr=0x40 while still stalled -> PC holds 5,5 then becomes 0x40.
- Call at PC=0x10 (jumpAddr=0x80, pushAddr=0x11), then later retValid at PC=0x85 -> PC=0x80, then 0x11; rasHit=1; rasEmpty=1 after the pop.
- 5 pushes of 0xA1..0xA5 with RAS_DEPTH=4, then 5 returns:
  - targets 0xA5,0xA4,0xA3,0xA2;
  - the 5th return has rasHit=0 and PC goes sequential;
  - rasFull=1 after push 4 and stays 1 after push 5.
- Redirect in the same cycle as callValid and retValid -> PC=redirectAddr, RAS count unchanged; at PC=0xFFFF with INC=1 -> next PC 0x0000.
- Assert Reset_N low between clock edges with count=2 and PC=0x33 -> outputAddr=0 and rasEmpty=1 immediately, before the next edge.

Source files
------------

// File: rtl/pc_ras_unit.sv
// pc_ras_unit: fetch-stage program counter with a circular return-address stack.
//
// The next fetch address is chosen by priority:
//   EX redirect > RAS return prediction > ID jump > sequential increment.
// The RAS is a circular buffer. When it is full, a new push overwrites the
// oldest entry.
//
// Ports
//   Clk, Reset_N             clock (rising edge), async active-low reset
//   pcWrite                  1 = advance the PC, 0 = stall
//   redirectValid/Addr       EX-stage redirect; also overrides a stall
//   jumpValid/Addr           ID-stage direct jump or call target
//   callValid, pushAddr      ID call; pushes its return address
//   retValid                 ID return; pops and predicts from the RAS
//   outputAddr               current PC (registered)
//   nextAddr                 next PC (combinational)
//   rasHit                   return predicted from a non-empty RAS (combinational)
//   rasEmpty, rasFull        RAS occupancy flags (registered)
module pc_ras_unit #(
    parameter int               WIDTH        = 16,
    parameter logic [WIDTH-1:0] RESET_VECTOR = '0,
    parameter int               INC          = 1,
    parameter int               RAS_DEPTH    = 4
) (
    input  logic             Clk,
    input  logic             Reset_N,
    input  logic             pcWrite,
    input  logic             redirectValid,
    input  logic [WIDTH-1:0] redirectAddr,
    input  logic             jumpValid,
    input  logic [WIDTH-1:0] jumpAddr,
    input  logic             callValid,
    input  logic [WIDTH-1:0] pushAddr,
    input  logic             retValid,
    output logic [WIDTH-1:0] outputAddr,
    output logic [WIDTH-1:0] nextAddr,
    output logic             rasHit,
    output logic             rasEmpty,
    output logic             rasFull
);
    localparam int PW = $clog2(RAS_DEPTH);
    localparam int CW = $clog2(RAS_DEPTH + 1);

    logic [WIDTH-1:0] pc_q, pc_d;
    logic [PW-1:0]    top_q, top_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             empty_q, empty_d;
    logic             full_q, full_d;
    logic [WIDTH-1:0] ras_q [RAS_DEPTH];
    logic [WIDTH-1:0] ras_d [RAS_DEPTH];

    logic             ret_hit;
    logic             ras_en;
    logic [PW-1:0]    top_inc;

    assign ret_hit = retValid && !empty_q;
    assign top_inc = top_q + PW'(1);
    // A redirect squashes the ID-stage call/return, so the RAS is left alone.
    assign ras_en  = pcWrite && !redirectValid;

    // Next-PC select
    always_comb begin
        if (redirectValid)  nextAddr = redirectAddr;
        else if (ret_hit)   nextAddr = ras_q[top_q];
        else if (jumpValid) nextAddr = jumpAddr;
        else                nextAddr = pc_q + WIDTH'(INC);
    end

    always_comb begin
        pc_d = pc_q;
        if (pcWrite || redirectValid) pc_d = nextAddr;
    end

    // RAS update
    always_comb begin
        ras_d = ras_q;
        top_d = top_q;
        cnt_d = cnt_q;
        if (ras_en) begin
            if (callValid && ret_hit) begin
                // The return consumes the old top, and the call refills that slot.
                ras_d[top_q] = pushAddr;
            end else if (callValid) begin
                ras_d[top_inc] = pushAddr;
                top_d          = top_inc;
                if (cnt_q != CW'(RAS_DEPTH)) cnt_d = cnt_q + CW'(1);
            end else if (ret_hit) begin
                top_d = top_q - PW'(1);
                cnt_d = cnt_q - CW'(1);
            end
        end
        empty_d = (cnt_d == '0);
        full_d  = (cnt_d == CW'(RAS_DEPTH));
    end

    always_ff @(posedge Clk or negedge Reset_N) begin
        if (!Reset_N) begin
            pc_q    <= RESET_VECTOR;
            top_q   <= '0;
            cnt_q   <= '0;
            empty_q <= 1'b1;
            full_q  <= 1'b0;
        end else begin
            pc_q    <= pc_d;
            top_q   <= top_d;
            cnt_q   <= cnt_d;
            empty_q <= empty_d;
            full_q  <= full_d;
        end
    end

    // Entry contents do not matter after reset, so the storage is not reset.
    always_ff @(posedge Clk) begin
        ras_q <= ras_d;
    end

    assign outputAddr = pc_q;
    assign rasHit     = ret_hit;
    assign rasEmpty   = empty_q;
    assign rasFull    = full_q;
endmodule

// File: tb/tb_pc_ras_unit.sv
// Directed bench for pc_ras_unit (WIDTH=16, INC=1, RAS_DEPTH=4, RESET_VECTOR=0).
module tb_pc_ras_unit;
    logic        Clk = 1'b0;
    logic        Reset_N;
    logic        pcWrite, redirectValid, jumpValid, callValid, retValid;
    logic [15:0] redirectAddr, jumpAddr, pushAddr;
    logic [15:0] outputAddr, nextAddr;
    logic        rasHit, rasEmpty, rasFull;

    int vectors = 0;
    int miscompares = 0;

    pc_ras_unit dut (
        .Clk(Clk), .Reset_N(Reset_N), .pcWrite(pcWrite),
        .redirectValid(redirectValid), .redirectAddr(redirectAddr),
        .jumpValid(jumpValid), .jumpAddr(jumpAddr),
        .callValid(callValid), .pushAddr(pushAddr), .retValid(retValid),
        .outputAddr(outputAddr), .nextAddr(nextAddr), .rasHit(rasHit),
        .rasEmpty(rasEmpty), .rasFull(rasFull)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        chk(tag, {15'b0, obs}, {15'b0, exp});
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic idle();
        pcWrite = 1'b1; redirectValid = 1'b0; jumpValid = 1'b0;
        callValid = 1'b0; retValid = 1'b0;
    endtask

    initial begin
        Reset_N = 1'b0;
        pcWrite = 1'b0; redirectValid = 1'b0; jumpValid = 1'b0;
        callValid = 1'b0; retValid = 1'b0;
        redirectAddr = '0; jumpAddr = '0; pushAddr = '0;
        #12;
        chk("rst_pc", outputAddr, 16'h0000);
        chk1("rst_empty", rasEmpty, 1'b1);
        chk1("rst_full", rasFull, 1'b0);
        Reset_N = 1'b1;

        // Sequential fetch straight out of reset
        idle();
        #1 chk("seq_next0", nextAddr, 16'h0001);
        step(); chk("seq_pc1", outputAddr, 16'h0001);
        step(); chk("seq_pc2", outputAddr, 16'h0002);
        step(); chk("seq_pc3", outputAddr, 16'h0003);
        chk1("seq_empty", rasEmpty, 1'b1);

        // Stall, then redirect while still stalled
        redirectValid = 1'b1; redirectAddr = 16'h0005;
        step(); chk("redir_pc5", outputAddr, 16'h0005);
        redirectValid = 1'b0; pcWrite = 1'b0;
        step(); chk("stall_a", outputAddr, 16'h0005);
        step(); chk("stall_b", outputAddr, 16'h0005);
        redirectValid = 1'b1; redirectAddr = 16'h0040;
        #1 chk("stall_redir_next", nextAddr, 16'h0040);
        step(); chk("stall_redir_pc", outputAddr, 16'h0040);

        // Call at 0x10 to 0x80, then return from 0x85
        idle(); redirectValid = 1'b1; redirectAddr = 16'h0010;
        step(); chk("call_at_pc", outputAddr, 16'h0010);
        idle(); callValid = 1'b1; jumpValid = 1'b1; jumpAddr = 16'h0080; pushAddr = 16'h0011;
        #1 chk("call_next", nextAddr, 16'h0080);
        step(); chk("call_pc", outputAddr, 16'h0080);
        chk1("call_nonempty", rasEmpty, 1'b0);
        idle();
        for (int i = 0; i < 5; i++) step();
        chk("pre_ret_pc", outputAddr, 16'h0085);
        retValid = 1'b1;
        #1 chk1("ret_hit", rasHit, 1'b1);
        chk("ret_next", nextAddr, 16'h0011);
        step(); chk("ret_pc", outputAddr, 16'h0011);
        chk1("ret_empty", rasEmpty, 1'b1);

        // Five pushes into a 4-entry stack, then five returns
        for (int i = 1; i <= 5; i++) begin
            idle(); callValid = 1'b1; jumpValid = 1'b1;
            jumpAddr = 16'h0100 + 16'(i); pushAddr = 16'h00A0 + 16'(i);
            step();
            if (i == 3) chk1("push3_notfull", rasFull, 1'b0);
            if (i == 4) chk1("push4_full", rasFull, 1'b1);
            if (i == 5) chk1("push5_full", rasFull, 1'b1);
        end
        for (int i = 0; i < 4; i++) begin
            idle(); retValid = 1'b1;
            #1 chk1("pop_hit", rasHit, 1'b1);
            chk("pop_next", nextAddr, 16'h00A5 - 16'(i));
            step(); chk("pop_pc", outputAddr, 16'h00A5 - 16'(i));
            if (i == 0) chk1("pop1_notfull", rasFull, 1'b0);
        end
        chk1("pop4_empty", rasEmpty, 1'b1);
        #1 chk1("pop5_miss", rasHit, 1'b0);
        chk("pop5_next", nextAddr, 16'h00A3);
        step(); chk("pop5_pc", outputAddr, 16'h00A3);
        chk1("pop5_empty", rasEmpty, 1'b1);

        // Push and pop together: predict the old top, then replace it
        idle(); callValid = 1'b1; pushAddr = 16'h00B1; step();
        idle(); callValid = 1'b1; pushAddr = 16'h00B2; step();
        idle(); callValid = 1'b1; retValid = 1'b1; pushAddr = 16'h00C0;
        #1 chk("pp_next", nextAddr, 16'h00B2);
        chk1("pp_hit", rasHit, 1'b1);
        step(); chk("pp_pc", outputAddr, 16'h00B2);
        idle(); retValid = 1'b1;
        #1 chk("pp_pop1", nextAddr, 16'h00C0);
        step();
        #1 chk("pp_pop2", nextAddr, 16'h00B1);
        step(); chk1("pp_empty", rasEmpty, 1'b1);
        // Push and pop on an empty stack acts as a push
        idle(); callValid = 1'b1; retValid = 1'b1; jumpValid = 1'b1;
        jumpAddr = 16'h0200; pushAddr = 16'h00D0;
        #1 chk1("ppe_miss", rasHit, 1'b0);
        chk("ppe_next", nextAddr, 16'h0200);
        step(); chk1("ppe_nonempty", rasEmpty, 1'b0);
        idle(); retValid = 1'b1;
        #1 chk("ppe_pop", nextAddr, 16'h00D0);
        step(); chk1("ppe_empty", rasEmpty, 1'b1);

        // A redirect squashes call and return together; then PC wraps
        idle(); callValid = 1'b1; pushAddr = 16'h00D1; step();
        idle(); callValid = 1'b1; pushAddr = 16'h00D2; step();
        idle(); redirectValid = 1'b1; redirectAddr = 16'hFFFF;
        callValid = 1'b1; retValid = 1'b1; pushAddr = 16'h00EE;
        #1 chk("rd_next", nextAddr, 16'hFFFF);
        step(); chk("rd_pc", outputAddr, 16'hFFFF);
        idle();
        #1 chk("wrap_next", nextAddr, 16'h0000);
        step(); chk("wrap_pc", outputAddr, 16'h0000);
        retValid = 1'b1;
        #1 chk("rd_pop1", nextAddr, 16'h00D2);
        step();
        #1 chk("rd_pop2", nextAddr, 16'h00D1);
        step(); chk1("rd_empty", rasEmpty, 1'b1);

        // Asynchronous reset between edges
        idle(); callValid = 1'b1; jumpValid = 1'b1; jumpAddr = 16'h0020; pushAddr = 16'h00E1; step();
        jumpAddr = 16'h0033; pushAddr = 16'h00E2; step();
        idle(); pcWrite = 1'b0;
        chk("arst_pre_pc", outputAddr, 16'h0033);
        #2 Reset_N = 1'b0;
        #1 chk("arst_pc", outputAddr, 16'h0000);
        chk1("arst_empty", rasEmpty, 1'b1);
        chk1("arst_full", rasFull, 1'b0);
        #1 Reset_N = 1'b1;
        idle(); retValid = 1'b1;
        #1 chk1("arst_miss", rasHit, 1'b0);
        step(); chk("arst_seq", outputAddr, 16'h0001);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
